// File: rtl/ifu_pkg.sv
// Shared fetch/decode definitions: next-PC select codes, the ROM address
// window, the fetch state encoding and the instruction ROM image.
package ifu_pkg;

    // next-PC select codes, identical to what the instruction decoder emits
    localparam logic [2:0] JS_SEQ    = 3'b000;
    localparam logic [2:0] JS_BRANCH = 3'b001;
    localparam logic [2:0] JS_J      = 3'b010;
    localparam logic [2:0] JS_JAL    = 3'b011;
    localparam logic [2:0] JS_JR     = 3'b100;

    // instruction ROM window: 4096 words starting at the reset vector
    localparam logic [31:0] PC_RESET     = 32'h0000_3000;
    localparam logic [31:0] ROM_LAST     = 32'h0000_6FFF;
    localparam int          ROM_DEPTH    = 4096;
    localparam logic [11:0] ROM_BASE_IDX = 12'hC00;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FAULT = 2'd2
    } ifu_state_e;

    // true when an address falls inside the instruction ROM window
    function automatic logic in_rom_range(input logic [31:0] addr);
        return (addr >= PC_RESET) && (addr <= ROM_LAST);
    endfunction

    // ROM image: a fixed scrambled pattern so every word is distinct and
    // word 0 is non-zero (a wrong index is visible on instr)
    function automatic logic [31:0] rom_image(input logic [11:0] idx);
        logic [31:0] w;
        w = {20'd0, idx} * 32'h9E37_79B1;
        return w ^ 32'h2108_0020 ^ {idx[5:0], 14'd0, idx};
    endfunction

endpackage

// File: rtl/ifu_npc.sv
// npc: combinational next-PC selection. Produces pc+4 (also the jal link
// value) and the candidate next PC; all arithmetic wraps modulo 2^32.
module npc
    import ifu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [2:0]  jump_signal,
    input  logic        br_cond,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_data,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic [31:0] br_offset;

    assign pc_plus4  = pc + 32'd4;
    // word offset sign-extended and scaled to bytes
    assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};

    // select the next PC; unused codes fall back to sequential
    always_comb begin
        next_pc = pc_plus4;
        case (jump_signal)
            JS_BRANCH:    next_pc = br_cond ? (pc_plus4 + br_offset) : pc_plus4;
            JS_J, JS_JAL: next_pc = {pc_plus4[31:28], instr_index, 2'b00};
            JS_JR:        next_pc = rs_data;
            default:      next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit. Holds the PC register, the RUN/HOLD/FAULT
// state machine and a 4096x32 combinational instruction ROM.
// Optional feature macro: IFU_ALIGN_CHECK_EN -- when defined, a misaligned
// or out-of-window next PC freezes the PC in FAULT and raises fetch_err;
// when undefined the next PC is loaded with bits[1:0] cleared and
// fetch_err is tied low.
// Handshake: there is none; stall=1 on a rising edge means "hold the PC",
// and any redirect presented in a cycle that is not loaded is dropped and
// must be re-presented by the upstream stage.
module ifu
    import ifu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  jump_signal,
    input  logic        br_cond,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic        fetch_err,
    output ifu_state_e  state
);

    logic [31:0] next_pc;
    logic [31:0] rom [ROM_DEPTH];
    logic [11:0] rom_idx;

    npc u_npc (
        .pc          (pc),
        .jump_signal (jump_signal),
        .br_cond     (br_cond),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_data     (rs_data),
        .pc_plus4    (pc_plus4),
        .next_pc     (next_pc)
    );

    // ROM contents are constant; each word comes from the package image
    for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
        assign rom[i] = rom_image(12'(i));
    end

    // zero-latency fetch: word index is (pc - PC_RESET) >> 2, nop outside the window
    assign rom_idx = pc[13:2] - ROM_BASE_IDX;
    assign instr   = in_rom_range(pc) ? rom[rom_idx] : 32'h0000_0000;
    assign op      = instr[31:26];
    assign func    = instr[5:0];

`ifdef IFU_ALIGN_CHECK_EN
    logic next_ok;
    assign next_ok = (next_pc[1:0] == 2'b00) && in_rom_range(next_pc);

    // PC register and fetch state machine; a bad next PC is never loaded
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= PC_RESET;
            state     <= ST_RUN;
            fetch_err <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (stall) begin
                        state <= ST_HOLD;
                    end else if (!next_ok) begin
                        state     <= ST_FAULT;
                        fetch_err <= 1'b1;
                    end else begin
                        pc <= next_pc;
                    end
                end
                ST_HOLD: begin
                    if (!stall) state <= ST_RUN;
                end
                ST_FAULT: begin
                    fetch_err <= 1'b1;
                end
                default: begin
                    state     <= ST_RUN;
                    fetch_err <= 1'b0;
                end
            endcase
        end
    end
`else
    assign fetch_err = 1'b0;

    // PC register and fetch state machine; next PC forced word-aligned
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= PC_RESET;
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (stall) state <= ST_HOLD;
                    else       pc    <= next_pc & ~32'd3;
                end
                ST_HOLD: begin
                    if (!stall) state <= ST_RUN;
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed scenarios followed by random stimulus. The
// driver pushes each cycle's expected outputs into exp_q from a
// behavioural model; a monitor pops and compares every cycle.
module tb_ifu;
    import ifu_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  jump_signal;
    logic        br_cond;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] rs_data;
    logic [31:0] pc, pc_plus4, instr;
    logic [5:0]  op, func;
    logic        fetch_err;
    ifu_state_e  state;

    always #5 clk = ~clk;

    ifu dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .jump_signal (jump_signal),
        .br_cond     (br_cond),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_data     (rs_data),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr       (instr),
        .op          (op),
        .func        (func),
        .fetch_err   (fetch_err),
        .state       (state)
    );

`ifdef IFU_ALIGN_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    // ---------------- scoreboard ----------------
    localparam int W = 111;
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    int          m_mode;   // 0 running, 1 holding, 2 faulted

    function automatic logic [31:0] ref_instr(input logic [31:0] a);
        if (a >= 32'h0000_3000 && a <= 32'h0000_6FFF)
            return rom_image(12'((a - 32'h0000_3000) / 4));
        return 32'h0;
    endfunction

    function automatic logic [31:0] ref_target(input logic [31:0] p, input logic [2:0] js,
                                               input logic brc, input logic [15:0] imm,
                                               input logic [25:0] idx, input logic [31:0] rs);
        logic [31:0] seq;
        int off;
        seq = p + 32'd4;
        off = $signed(imm);
        case (js)
            3'd1:    return brc ? seq + 32'(off * 4) : seq;
            3'd2,
            3'd3:    return (seq & 32'hF000_0000) | (32'(idx) << 2);
            3'd4:    return rs;
            default: return seq;
        endcase
    endfunction

    task automatic push_expected();
        logic [31:0] ins;
        logic [1:0]  st;
        ins = ref_instr(m_pc);
        st  = (m_mode == 0) ? ST_RUN : (m_mode == 1) ? ST_HOLD : ST_FAULT;
        exp_q.push_back({m_pc, m_pc + 32'd4, ins, ins[31:26], ins[5:0], (m_mode == 2), st});
    endtask

    task automatic model_update(input logic rst, input logic stl, input logic [2:0] js,
                                input logic brc, input logic [15:0] imm,
                                input logic [25:0] idx, input logic [31:0] rs);
        logic [31:0] t;
        if (rst) begin
            m_pc   = 32'h0000_3000;
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (stl) begin
                m_mode = 1;
            end else begin
                t = ref_target(m_pc, js, brc, imm, idx, rs);
                if (CHECK_EN && ((t % 4) != 0 || t < 32'h3000 || t > 32'h6FFF))
                    m_mode = 2;
                else
                    m_pc = t - (t % 4);
            end
        end else if (m_mode == 1) begin
            if (!stl) m_mode = 0;
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic rst, input logic stl, input logic [2:0] js,
                        input logic brc, input logic [15:0] imm,
                        input logic [25:0] idx, input logic [31:0] rs);
        @(negedge clk);
        reset       = rst;
        stall       = stl;
        jump_signal = js;
        br_cond     = brc;
        imm16       = imm;
        instr_index = idx;
        rs_data     = rs;
        push_expected();
        model_update(rst, stl, js, brc, imm, idx, rs);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("pc",        pc,                 e[110:79]);
                cmp("pc_plus4",  pc_plus4,           e[78:47]);
                cmp("instr",     instr,              e[46:15]);
                cmp("op",        32'(op),            32'(e[14:9]));
                cmp("func",      32'(func),          32'(e[8:3]));
                cmp("fetch_err", 32'(fetch_err),     32'(e[2]));
                cmp("state",     32'(state),         32'(e[1:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic        r_rst, r_stl, r_brc;
        logic [2:0]  r_js;
        logic [15:0] r_imm;
        logic [25:0] r_idx;
        logic [31:0] r_rs;

        reset = 1'b1; stall = 1'b0; jump_signal = 3'd0; br_cond = 1'b0;
        imm16 = 16'h0; instr_index = 26'h0; rs_data = 32'h0;
        repeat (2) @(posedge clk);
        m_pc   = 32'h0000_3000;
        m_mode = 0;

        // reset then sequential fetch 0x3000..0x300C
        step(1'b1, 1'b0, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        repeat (4) idle();
        // at 0x3010: taken backward branch to 0x3004
        step(1'b0, 1'b0, 3'd1, 1'b1, 16'hFFFC, 26'h0, 32'h0);
        repeat (3) idle();
        // at 0x3010 again: not-taken branch to 0x3014
        step(1'b0, 1'b0, 3'd1, 1'b0, 16'hFFFC, 26'h0, 32'h0);
        // j to 0x3020, then jal to 0x3100
        step(1'b0, 1'b0, 3'd2, 1'b0, 16'h0, 26'h0000C08, 32'h0);
        step(1'b0, 1'b0, 3'd3, 1'b0, 16'h0, 26'h0000C40, 32'h0);
        idle();
        // j to 0x3008, then two stalled cycles with a j request dropped
        step(1'b0, 1'b0, 3'd2, 1'b0, 16'h0, 26'h0000C02, 32'h0);
        step(1'b0, 1'b1, 3'd2, 1'b0, 16'h0, 26'h0001000, 32'h0);
        step(1'b0, 1'b1, 3'd2, 1'b0, 16'h0, 26'h0001000, 32'h0);
        idle();
        idle();
        idle();
        // reset while holding
        step(1'b0, 1'b1, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        step(1'b1, 1'b1, 3'd2, 1'b0, 16'h0, 26'h0001000, 32'h0);
        idle();
        // jr to a misaligned address
        step(1'b0, 1'b0, 3'd4, 1'b0, 16'h0, 26'h0, 32'h0000_3002);
        idle();
        idle();
        // reset (from FAULT when the check is enabled)
        step(1'b1, 1'b0, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        idle();
        // jumps outside the ROM window and unused select codes
        step(1'b0, 1'b0, 3'd2, 1'b0, 16'h0, 26'h0, 32'h0);
        idle();
        step(1'b0, 1'b0, 3'd7, 1'b1, 16'h0010, 26'h0, 32'h0);
        step(1'b0, 1'b0, 3'd4, 1'b0, 16'h0, 26'h0, 32'h0000_6FFC);
        idle();
        step(1'b1, 1'b0, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0);

        // random phase
        for (int i = 0; i < 1500; i++) begin
            r_rst = ($urandom_range(0, 63) == 0);
            r_stl = ($urandom_range(0, 4) == 0);
            r_js  = 3'($urandom_range(0, 7));
            r_brc = 1'($urandom_range(0, 1));
            r_imm = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                : 16'($urandom_range(0, 63)) - 16'd32;
            r_idx = ($urandom_range(0, 3) == 0) ? 26'($urandom)
                                                : 26'($urandom_range(32'hC00, 32'h1BFF));
            r_rs  = ($urandom_range(0, 3) == 0) ? $urandom
                                                : 32'h3000 + 32'($urandom_range(0, 16383));
            step(r_rst, r_stl, r_js, r_brc, r_imm, r_idx, r_rs);
        end

        @(negedge clk);
        #2;
        cmp("drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
